// File: rtl/arbitro_rr_if.sv
// Bundle of source-FIFO, destination-FIFO and status signals around the round-robin arbiter.
// The slave modport is the arbiter side; the master modport is the surrounding FIFO fabric.
interface arbitro_rr_if #(
  parameter int DATA_WIDTH = 6
);
  logic [3:0]            state;
  logic [3:0]            empty_naranja;
  logic [DATA_WIDTH-1:0] data_in0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic [DATA_WIDTH-1:0] data_in2;
  logic [DATA_WIDTH-1:0] data_in3;
  logic [3:0]            almost_full;
  logic [3:0]            pop;
  logic [3:0]            push;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            grant;
  logic                  idle;

  modport master (
    output state, empty_naranja, data_in0, data_in1, data_in2, data_in3, almost_full,
    input  pop, push, data_out, grant, idle
  );

  modport slave (
    input  state, empty_naranja, data_in0, data_in1, data_in2, data_in3, almost_full,
    output pop, push, data_out, grant, idle
  );
endinterface

// File: rtl/arbitro_rr.sv
// Round-robin arbiter moving head words from four FWFT source FIFOs to four destination FIFOs.
// Pop is combinational from the current heads; push/data_out/grant follow one cycle later.
module arbitro_rr #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_LSB   = 4
) (
  input  logic          clk,
  input  logic          reset,
  arbitro_rr_if.slave   bus
);

  logic                  enabled;
  logic [DATA_WIDTH-1:0] data_in_arr [4];
  logic [1:0]            dest_arr [4];
  logic [3:0]            eligible;

  logic [1:0]            ptr_reg;
  logic [3:0]            push_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic [1:0]            grant_reg;
  logic                  idle_reg;

  logic                  found_next;
  logic [1:0]            sel_next;
  logic [1:0]            scan_idx;
  logic [3:0]            pop_next;

  assign data_in_arr[0] = bus.data_in0;
  assign data_in_arr[1] = bus.data_in1;
  assign data_in_arr[2] = bus.data_in2;
  assign data_in_arr[3] = bus.data_in3;

  // Non-one-hot state values fall through to disabled.
  assign enabled = (bus.state == 4'b0100) || (bus.state == 4'b1000);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
      assign dest_arr[gi] = data_in_arr[gi][DEST_LSB+1:DEST_LSB];
      assign eligible[gi] = enabled && !bus.empty_naranja[gi] && !bus.almost_full[dest_arr[gi]];
      assign pop_next[gi] = found_next && (sel_next == 2'(gi));
    end
  endgenerate

  always_comb begin
    found_next = 1'b0;
    sel_next   = 2'd0;
    scan_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_reg + 2'(k);
      if (!found_next && eligible[scan_idx]) begin
        found_next = 1'b1;
        sel_next   = scan_idx;
      end
    end
    if (reset) begin
      found_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg      <= 2'd0;
      push_reg     <= 4'b0000;
      data_out_reg <= '0;
      grant_reg    <= 2'd0;
      idle_reg     <= 1'b1;
    end else begin
      if (found_next) begin
        data_out_reg <= data_in_arr[sel_next];
        push_reg     <= 4'b0001 << dest_arr[sel_next];
        grant_reg    <= sel_next;
        ptr_reg      <= sel_next + 2'd1;
      end else begin
        push_reg     <= 4'b0000;
      end
      idle_reg <= (&bus.empty_naranja) && !found_next;
    end
  end

  assign bus.pop      = pop_next;
  assign bus.push     = push_reg;
  assign bus.data_out = data_out_reg;
  assign bus.grant    = grant_reg;
  assign bus.idle     = idle_reg;

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: fixed vector table, directed corner sequences and
// randomized traffic compared against a behavioural arbitration model.
module tb_arbitro_rr;
  localparam int DW = 6;
  localparam int DL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arbitro_rr_if #(.DATA_WIDTH(DW)) bus ();
  arbitro_rr #(.DATA_WIDTH(DW), .DEST_LSB(DL)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int          m_ptr;
  logic [3:0]  m_push;
  logic [5:0]  m_data;
  int          m_grant;
  logic        m_idle;
  logic [3:0]  seen_pop;

  typedef struct {
    bit         rst;
    logic [3:0] st, emp, af;
    logic [5:0] d0, d1, d2, d3;
    logic [3:0] e_pop, e_push;
    logic [5:0] e_data;
    logic [1:0] e_grant;
    logic       e_idle;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dest_of(input logic [5:0] w);
    return (int'(w) >> DL) % 4;
  endfunction

  // Arbitration rule from the requirements: first eligible source from ptr upward, mod 4.
  function automatic int model_sel();
    logic [5:0] d [4];
    int i;
    d[0] = bus.data_in0; d[1] = bus.data_in1; d[2] = bus.data_in2; d[3] = bus.data_in3;
    if (reset) return -1;
    if (bus.state != 4'b0100 && bus.state != 4'b1000) return -1;
    for (int k = 0; k < 4; k++) begin
      i = (m_ptr + k) % 4;
      if (!bus.empty_naranja[i] && !bus.almost_full[dest_of(d[i])]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_push = 4'b0; m_data = 6'h0; m_grant = 0; m_idle = 1'b1;
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] emp, input logic [3:0] af,
                       input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2,
                       input logic [5:0] d3);
    bus.state = st; bus.empty_naranja = emp; bus.almost_full = af;
    bus.data_in0 = d0; bus.data_in1 = d1; bus.data_in2 = d2; bus.data_in3 = d3;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " push"}, int'(bus.push), int'(m_push));
    chk({tag, " data_out"}, int'(bus.data_out), int'(m_data));
    chk({tag, " grant"}, int'(bus.grant), m_grant);
    chk({tag, " idle"}, int'(bus.idle), int'(m_idle));
    chk({tag, " push onehot"}, int'($countones(bus.push) <= 1), 1);
  endtask

  // One clock: check combinational pop, advance model at the edge, check registered outputs.
  task automatic cycle(input string tag);
    int s;
    logic [3:0] exp_pop;
    logic [3:0] emp_s;
    logic [5:0] d [4];
    #1;
    s = model_sel();
    exp_pop = (s < 0) ? 4'b0000 : (4'b0001 << s);
    seen_pop = bus.pop;
    chk({tag, " pop"}, int'(bus.pop), int'(exp_pop));
    chk({tag, " pop onehot"}, int'($countones(bus.pop) <= 1), 1);
    emp_s = bus.empty_naranja;
    d[0] = bus.data_in0; d[1] = bus.data_in1; d[2] = bus.data_in2; d[3] = bus.data_in3;
    @(posedge clk);
    if (s >= 0) begin
      m_data  = d[s];
      m_push  = 4'b0001 << dest_of(d[s]);
      m_grant = s;
      m_ptr   = (s + 1) % 4;
    end else begin
      m_push = 4'b0000;
    end
    m_idle = (emp_s == 4'hF) && (s < 0);
    #1;
    check_regs(tag);
    $display("%s st=%b emp=%b af=%b pop=%b push=%b data=%h grant=%0d idle=%b",
             tag, bus.state, emp_s, bus.almost_full, seen_pop, bus.push, bus.data_out,
             bus.grant, bus.idle);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " push"}, int'(bus.push), 0);
    chk({tag, " data_out"}, int'(bus.data_out), 0);
    chk({tag, " grant"}, int'(bus.grant), 0);
    chk({tag, " idle"}, int'(bus.idle), 1);
    chk({tag, " pop"}, int'(bus.pop), 0);
  endtask

  // Full reset held across an edge; leaves time at posedge+1.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_cleared("rst async");
    model_reset();
    @(posedge clk);
    #1;
    check_cleared("rst held");
    reset = 1'b0;
  endtask

  // Reset pulse that starts and ends between clock edges.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check_cleared("rst pulse");
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  int got;

  initial begin
    drive(4'b0001, 4'hF, 4'h0, 6'h0, 6'h0, 6'h0, 6'h0);
    model_reset();
    #2;

    // rst st emp af d0 d1 d2 d3 | pop push data grant idle
    tbl[0]  = '{1'b1, 4'b1000, 4'b1110, 4'b0000, 6'h25, 6'h00, 6'h00, 6'h00, 4'b0001, 4'b0100, 6'h25, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0001, 4'b0001, 6'h01, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0010, 4'b0001, 6'h02, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0100, 4'b0001, 6'h03, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b1000, 4'b0001, 6'h04, 2'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0001, 4'b0001, 6'h01, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0000, 4'b0000, 6'h01, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0010, 4'b0001, 6'h02, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 4'b1100, 4'b0000, 4'b0000, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0000, 4'b0000, 6'h02, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 4'b1000, 4'b0000, 4'b0001, 6'h01, 6'h02, 6'h03, 6'h04, 4'b0000, 4'b0000, 6'h02, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 4'b1000, 4'b0000, 4'b0001, 6'h15, 6'h02, 6'h03, 6'h04, 4'b0001, 4'b0010, 6'h15, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 4'b1000, 4'b1111, 4'b0000, 6'h15, 6'h02, 6'h03, 6'h04, 4'b0000, 4'b0000, 6'h15, 2'd0, 1'b1};

    do_reset();
    for (int r = 0; r < 12; r++) begin
      if (tbl[r].rst) do_reset();
      drive(tbl[r].st, tbl[r].emp, tbl[r].af, tbl[r].d0, tbl[r].d1, tbl[r].d2, tbl[r].d3);
      cycle($sformatf("vec%0d", r));
      chk($sformatf("vec%0d tbl pop", r), int'(seen_pop), int'(tbl[r].e_pop));
      chk($sformatf("vec%0d tbl push", r), int'(bus.push), int'(tbl[r].e_push));
      chk($sformatf("vec%0d tbl data", r), int'(bus.data_out), int'(tbl[r].e_data));
      chk($sformatf("vec%0d tbl grant", r), int'(bus.grant), int'(tbl[r].e_grant));
      chk($sformatf("vec%0d tbl idle", r), int'(bus.idle), int'(tbl[r].e_idle));
    end

    // Source 0 blocked on an almost-full destination must not stall the others.
    do_reset();
    drive(4'b1000, 4'b0000, 4'b0010, 6'h15, 6'h31, 6'h32, 6'h33);
    for (int c = 0; c < 6; c++) begin
      cycle($sformatf("hol%0d", c));
      chk($sformatf("hol%0d src0 skipped", c), int'(seen_pop[0]), 0);
      chk($sformatf("hol%0d others served", c), int'(seen_pop != 4'b0000), 1);
    end
    drive(4'b1000, 4'b0000, 4'b0000, 6'h15, 6'h31, 6'h32, 6'h33);
    got = 0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      cycle($sformatf("rel%0d", c));
      if (seen_pop[0]) got = 1;
    end
    chk("src0 granted within 4", got, 1);

    // Disable right after a pop: the registered push still appears once.
    drive(4'b1000, 4'b0000, 4'b0000, 6'h01, 6'h12, 6'h23, 6'h34);
    cycle("dis pop");
    chk("dis push after pop", int'(bus.push != 4'b0000), 1);
    drive(4'b0010, 4'b0000, 4'b0000, 6'h01, 6'h12, 6'h23, 6'h34);
    for (int c = 0; c < 3; c++) begin
      cycle($sformatf("dis%0d", c));
      chk($sformatf("dis%0d no pop", c), int'(seen_pop), 0);
      chk($sformatf("dis%0d no push", c), int'(bus.push), 0);
    end
    drive(4'b0100, 4'b0000, 4'b0000, 6'h01, 6'h12, 6'h23, 6'h34);
    cycle("dis resume");
    chk("dis resume pop", int'(seen_pop != 4'b0000), 1);

    // Reset pulsed between edges while traffic flows.
    drive(4'b1000, 4'b0000, 4'b0000, 6'h05, 6'h16, 6'h27, 6'h38);
    cycle("flow0");
    cycle("flow1");
    pulse_reset();
    cycle("after pulse");
    chk("after pulse first grant", int'(seen_pop), 1);
    chk("after pulse grant", int'(bus.grant), 0);

    // Alternating empties.
    for (int c = 0; c < 16; c++) begin
      drive(4'b1000, (c % 2 == 0) ? 4'b1010 : 4'b1101, 4'b0000,
            6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
      cycle($sformatf("alt%0d", c));
      chk($sformatf("alt%0d pop only nonempty", c), int'(seen_pop & bus.empty_naranja), 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [3:0] st_pick [8];
      st_pick[0] = 4'b1000; st_pick[1] = 4'b1000; st_pick[2] = 4'b0100; st_pick[3] = 4'b0100;
      st_pick[4] = 4'b1000; st_pick[5] = 4'b0010; st_pick[6] = 4'b0001; st_pick[7] = 4'b1100;
      drive(st_pick[$urandom_range(0, 7)], 4'($urandom),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
            6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
      cycle($sformatf("rnd%0d", c));
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 Parameter: DATA_WIDTH, 6, width of every data word.
REQ-002 Parameter: DEST_LSB, 4, LSB of the 2-bit destination field inside a data word (bits DEST_LSB+1:DEST_LSB).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 state  input  4  one-hot system state: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE.
REQ-006 empty_naranja  input  4  bit i high = source FIFO i empty.
REQ-007 data_in0..data_in3  input  DATA_WIDTH each  head word of source FIFO i; FIFOs are first-word fall-through.
REQ-008 almost_full  input  4  bit j high = destination FIFO j almost full.
REQ-009 pop  output  4  one-hot (or zero) pop strobe to the source FIFOs.
REQ-010 push  output  4  one-hot (or zero) push strobe to the destination FIFOs.
REQ-011 data_out  output  DATA_WIDTH  word written to the destination FIFO selected by push.
REQ-012 grant  output  2  index of the source last granted.
REQ-013 idle  output  1  high when no work is present or in flight.

Function
REQ-014 The block SHALL be enabled only when state is 0100 or 1000; any other value, including non-one-hot, SHALL disable it.
REQ-015 Source i SHALL be eligible when enabled, empty_naranja[i]=0, and almost_full[dest(data_in_i)]=0.
REQ-016 pop SHALL be combinational: exactly one bit, for the first eligible source scanning ptr, ptr+1, ... ptr+3 (mod 4); zero when no source is eligible.
REQ-017 On each rising edge with pop[i]=1: data_out <= data_in_i, push <= one-hot of dest(data_in_i), grant <= i, ptr <= (i+1) mod 4.
REQ-018 On a rising edge with pop=0: push SHALL be 0000; data_out, grant and ptr SHALL hold.
REQ-019 Latency SHALL be exactly one cycle from a pop to the matching push; throughput SHALL be one word per cycle.
REQ-020 A source whose destination is almost full SHALL be skipped without blocking other sources (no cross-source head-of-line blocking).
REQ-021 Multiple sources targeting one destination SHALL be served in round-robin order; no source is starved while its destination stays not-almost-full.
REQ-022 A push registered before the block becomes disabled SHALL still be driven on the following cycle; no new pop SHALL occur while disabled.
REQ-023 almost_full SHALL be sampled only in the pop cycle; almost_full rising on the push cycle does not cancel that push.
REQ-024 idle SHALL be registered: high when, at the previous edge, all empty_naranja bits were 1 and no pop occurred.
REQ-025 pop and push SHALL never have more than one bit set.

Reset
REQ-026 While reset is high: push=0000, data_out=0, grant=00, ptr=0, idle=1, asynchronously and without waiting for clk.
REQ-027 pop SHALL be 0000 while reset is high regardless of other inputs.
REQ-028 Reset asserted mid-transfer SHALL drop the pending push; the word already popped is lost and this is accepted.
REQ-029 After reset release the first grant SHALL go to the lowest-index eligible source starting from source 0.

Verification
REQ-030 Reset, state=1000, empty_naranja=1110, data_in0=6'h25 (dest 2), almost_full=0000 -> pop=0001 combinationally; next cycle push=0100, data_out=6'h25, grant=00.
REQ-031 All four sources non-empty, dest 0 for all, held 5 cycles -> pop sequence 0001,0010,0100,1000,0001; push=0001 every cycle from the second.
REQ-032 empty_naranja=0000, source 0 dest 1 with almost_full=0010, others dest 3 -> source 0 never popped; sources 1,2,3 rotate; release almost_full -> source 0 granted within 4 cycles.
REQ-033 Word popped with state=1000, state set to 0010 the same edge -> push still asserted once next cycle, then pop=0000 and push=0000 until state returns to 0100/1000.
REQ-034 Traffic flowing, reset pulsed between edges -> push, data_out, grant cleared immediately; idle=1; after release first grant goes to source 0.
REQ-035 empty_naranja alternating 1010 then 1101 every cycle, almost_full=0000 -> only non-empty sources popped, pop one-hot throughout, idle=0 whenever a pop occurred at the prior edge.
